// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Opcodes, funct3 codes, controller states and access sizes.
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        FIN  = 3'd3,
        ERR  = 3'd4
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit.
// Builds store enables/data and extracts/extends load data.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size_i,
    input  logic [1:0]  off_i,
    input  logic        sign_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select for both directions from size and low address bits
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'd0;
        ldata_o = 32'd0;
        byte_s  = rdata_i[{off_i, 3'b000} +: 8];
        half_s  = rdata_i[{off_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{sdata_i[7:0]}};
                ldata_o = {{24{sign_i & byte_s[7]}}, byte_s};
            end
            SZ_H: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{sdata_i[15:0]}};
                ldata_o = {{16{sign_i & half_s[15]}}, half_s};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wdata_o = sdata_i;
                ldata_o = rdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'd0;
                ldata_o = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit, one access in flight.
// req/gnt/rvalid memory port, aligned load data to reg_file.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
)
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    input  logic [31:0] inst,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err,
    output logic [31:0] busW,
    output logic        RegWr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    lsu_size_e   size_q, size_d;
    logic        sign_q, sign_d;
    logic        we_q, we_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic [31:0] busW_q, busW_d;

    logic [6:0]  opc_dec;
    logic [2:0]  f3_dec;
    logic        is_ld, is_st;
    logic [11:0] imm_dec;
    logic [31:0] addr_dec;
    lsu_size_e   size_dec;
    logic        legal_dec;
    logic        align_ok;

    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ldata_s;

    lsu_align u_align (
        .size_i  (size_q),
        .off_i   (addr_q[1:0]),
        .sign_i  (sign_q),
        .sdata_i (sdata_q),
        .rdata_i (mem_rdata),
        .be_o    (be_s),
        .wdata_o (wdata_s),
        .ldata_o (ldata_s)
    );

    // Decode the presented instruction into address, size and legality
    always_comb begin
        opc_dec   = inst[6:0];
        f3_dec    = inst[14:12];
        is_ld     = (opc_dec == OPC_LOAD);
        is_st     = (opc_dec == OPC_STORE);
        imm_dec   = is_st ? {inst[31:25], inst[11:7]} : inst[31:20];
        addr_dec  = rs1 + sext12(imm_dec);
        size_dec  = SZ_B;
        legal_dec = 1'b0;
        align_ok  = 1'b1;
        case (f3_dec)
            F3_B:  begin size_dec = SZ_B; legal_dec = is_ld | is_st; end
            F3_H:  begin size_dec = SZ_H; legal_dec = is_ld | is_st; end
            F3_W:  begin size_dec = SZ_W; legal_dec = is_ld | is_st; end
            F3_BU: begin size_dec = SZ_B; legal_dec = is_ld; end
            F3_HU: begin size_dec = SZ_H; legal_dec = is_ld; end
            default: begin size_dec = SZ_B; legal_dec = 1'b0; end
        endcase
        case (size_dec)
            SZ_H:    align_ok = ~addr_dec[0];
            SZ_W:    align_ok = (addr_dec[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    // Controller next state, latched access fields and outputs
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sign_d  = sign_q;
        we_d    = we_q;
        sdata_d = sdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        busW_d  = busW_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = addr_dec;
                    size_d  = size_dec;
                    sign_d  = ~f3_dec[2];
                    we_d    = is_st;
                    sdata_d = rs2;
                    cnt_d   = 32'd0;
                    tmo_d   = 1'b0;
                    state_d = (legal_dec && align_ok) ? REQ : ERR;
                end
            end
            REQ: begin
                cnt_d = 32'd0;
                if (mem_gnt) begin
                    state_d = we_q ? FIN : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    busW_d  = ldata_s;
                    state_d = FIN;
                end else if (TIMEOUT != 0 && cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy       = (state_q != IDLE);
        mem_req    = (state_q == REQ);
        done       = (state_q == FIN);
        RegWr      = (state_q == FIN) & ~we_q;
        misaligned = (state_q == ERR) & ~tmo_q;
        bus_err    = (state_q == ERR) & tmo_q;
        busW       = busW_q;
        mem_we     = mem_req & we_q;
        mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_be     = mem_req ? be_s : 4'b0000;
        mem_wdata  = mem_req ? wdata_s : 32'd0;
    end

    // State and access registers, cleared asynchronously
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            size_q  <= SZ_B;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            sdata_q <= 32'd0;
            cnt_q   <= 32'd0;
            tmo_q   <= 1'b0;
            busW_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            we_q    <= we_d;
            sdata_q <= sdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            busW_q  <= busW_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level model.
// Second instance with TIMEOUT=4 exercises the bus-error path.
module tb_load_store_unit;

    localparam int TM = 64;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_t4 = 1'b0;
    logic [31:0] inst = 32'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        busy, done, misaligned, bus_err, RegWr;
    logic        mem_req, mem_we;
    logic [31:0] busW, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        busy4, done4, mis4, berr4, regwr4, req4, we4;
    logic [31:0] busW4, addr4, wdata4;
    logic [3:0]  be4;

    always #5 Clk = ~Clk;

    load_store_unit #(.TIMEOUT(TM)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .inst(inst),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done),
        .misaligned(misaligned), .bus_err(bus_err), .busW(busW),
        .RegWr(RegWr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.TIMEOUT(4)) dut_t4 (
        .Clk(Clk), .Rst_n(Rst_n), .start(start_t4), .inst(inst),
        .rs1(rs1), .rs2(rs2), .busy(busy4), .done(done4),
        .misaligned(mis4), .bus_err(berr4), .busW(busW4),
        .RegWr(regwr4), .mem_req(req4), .mem_we(we4),
        .mem_addr(addr4), .mem_be(be4), .mem_wdata(wdata4),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_pass = 0;

    // expectations for the current cycle, set by the driver
    logic        chk_en = 1'b0;
    logic        e_busy = 0, e_req = 0, e_done = 0, e_mis = 0;
    logic        e_berr = 0, e_regwr = 0, e_we = 0, e_chkw = 0;
    logic [31:0] e_addr = 0, e_wdata = 0;
    logic [3:0]  e_be = 0;
    logic [31:0] m_busw = 0;

    // observation log for literal checks
    logic [31:0] last_addr = 0, last_wdata = 0;
    logic [3:0]  last_be = 0;
    logic        last_we = 0;
    int          n_regwr = 0, n_done = 0, n_req = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] enc_ld(input logic [2:0] f3,
                                           input logic [11:0] imm);
        return {imm, 5'd1, f3, 5'd5, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_st(input logic [2:0] f3,
                                           input logic [11:0] imm);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] w,
                                           input int off);
        logic [31:0] v;
        v = w >> (8 * off);
        case (f3)
            3'd0: begin v = v & 32'hFF; if (v[7]) v = v | 32'hFFFFFF00; end
            3'd1: begin v = v & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input int off);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input int sz,
                                            input logic [31:0] d);
        if (sz == 1) return {4{d[7:0]}};
        if (sz == 2) return {2{d[15:0]}};
        return d;
    endfunction

    // per-cycle comparison of the main DUT against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
            chk("done", {31'd0, done}, {31'd0, e_done});
            chk("RegWr", {31'd0, RegWr}, {31'd0, e_regwr});
            chk("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
            chk("bus_err", {31'd0, bus_err}, {31'd0, e_berr});
            chk("busW", busW, m_busw);
            if (e_req) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_be", {28'd0, mem_be}, {28'd0, e_be});
                chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
                if (e_chkw) chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    // activity log used by the directed literal checks
    always @(negedge Clk) begin
        if (mem_req) begin
            last_addr  = mem_addr;
            last_be    = mem_be;
            last_wdata = mem_wdata;
            last_we    = mem_we;
            n_req++;
        end
        if (RegWr) n_regwr++;
        if (done) n_done++;
    end

    task automatic set_idle_exp();
        e_busy = 0; e_req = 0; e_done = 0; e_mis = 0;
        e_berr = 0; e_regwr = 0; e_we = 0; e_chkw = 0;
    endtask

    // one access: gd = cycles before gnt, rd = WAIT cycles before rvalid
    task automatic run_txn(input logic [31:0] in, input logic [31:0] a,
                           input logic [31:0] b, input int gd,
                           input int rd, input logic [31:0] rdat);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [31:0] ea, lv;
        logic        ld, st, legal, bad, rv, tmo;
        int          sz, off, last;
        opc = in[6:0];
        f3  = in[14:12];
        ld  = (opc == 7'h03);
        st  = (opc == 7'h23);
        imm = st ? {in[31:25], in[11:7]} : in[31:20];
        ea  = a + 32'($signed(imm));
        off = int'(ea[1:0]);
        sz  = 1;
        legal = 0;
        case (f3)
            3'd0: begin sz = 1; legal = ld | st; end
            3'd1: begin sz = 2; legal = ld | st; end
            3'd2: begin sz = 4; legal = ld | st; end
            3'd4: begin sz = 1; legal = ld; end
            3'd5: begin sz = 2; legal = ld; end
            default: begin sz = 1; legal = 0; end
        endcase
        bad = !legal || ((off % sz) != 0);
        tmo = ld && (rd >= TM);
        lv  = m_load(f3, rdat, off);
        if (bad) last = 1;
        else if (st) last = 2 + gd;
        else if (!tmo) last = 3 + gd + rd;
        else last = 2 + gd + TM;
        for (int c = 0; c <= last; c++) begin
            @(posedge Clk); #1;
            start = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            inst = in; rs1 = a; rs2 = b;
            mem_gnt = !bad && (c == 1 + gd);
            mem_rdata = $urandom;
            rv = 0;
            if (!bad && ld) begin
                if (!tmo && c == 2 + gd + rd) begin
                    rv = 1; mem_rdata = rdat;
                end else if (tmo && c == last) rv = 1;
                else if (c <= 1 + gd) rv = 1'($urandom_range(0, 1));
            end else begin
                rv = 1'($urandom_range(0, 1));
            end
            mem_rvalid = rv;
            e_busy  = (c >= 1);
            e_req   = !bad && c >= 1 && c <= 1 + gd;
            e_done  = !bad && c == last && !tmo;
            e_regwr = e_done && ld;
            e_mis   = bad && c == 1;
            e_berr  = tmo && c == last;
            e_addr  = {ea[31:2], 2'b00};
            e_be    = m_be(sz, off);
            e_we    = st;
            e_chkw  = st;
            e_wdata = m_wdata(sz, b);
            if (e_regwr) m_busw = lv;
        end
        @(negedge Clk); #1;
        start = 0; mem_gnt = 0; mem_rvalid = 0;
        set_idle_exp();
    endtask

    task automatic t4_timeout();
        for (int c = 0; c <= 7; c++) begin
            @(posedge Clk); #1;
            start_t4 = (c == 0);
            inst = enc_ld(3'b010, 12'd0);
            rs1 = 32'h200;
            mem_gnt = (c == 1);
            mem_rvalid = 0;
            @(negedge Clk);
            chk("t4_busy", {31'd0, busy4}, {31'd0, (c >= 1 && c <= 6)});
            chk("t4_req", {31'd0, req4}, {31'd0, (c == 1)});
            chk("t4_bus_err", {31'd0, berr4}, {31'd0, (c == 6)});
            chk("t4_no_done", {31'd0, regwr4 | done4 | mis4}, 32'd0);
        end
        start_t4 = 0; mem_gnt = 0;
    endtask

    task automatic rand_txn();
        logic [31:0] in, a, ea;
        logic [11:0] imm;
        logic [2:0]  f3;
        int          k, gd, rd;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        imm = 12'($urandom);
        f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
             legal_f3[$urandom_range(0, 4)];
        k = $urandom_range(0, 9);
        if (k == 0) in = {$urandom} & 32'hFFFF_FF80 | 32'($urandom_range(0, 127));
        else if (k <= 5) in = enc_ld(f3, imm);
        else in = enc_st(f3, imm);
        if (in[6:0] == 7'h23) imm = {in[31:25], in[11:7]};
        else imm = in[31:20];
        a = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            ea = a + 32'($signed(imm));
            a = a - {30'd0, ea[1:0]};
        end
        gd = $urandom_range(0, 3);
        rd = ($urandom_range(0, 19) == 0) ? $urandom_range(TM, TM + 2)
                                          : $urandom_range(0, 6);
        run_txn(in, a, $urandom, gd, rd, $urandom);
    endtask

    initial begin
        int r0, d0, q0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_busW", busW, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be_wd", {28'd0, mem_be} | mem_wdata, 32'd0);
        chk("rst_flags", {26'd0, done, misaligned, bus_err, RegWr,
                          mem_req, mem_we}, 32'd0);
        chk("rst_t4", busW4 | addr4 | wdata4 | {28'd0, be4}, 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1;
        chk_en = 1;

        r0 = n_regwr;
        run_txn(enc_ld(3'b010, 12'd4), 32'h100, 0, 0, 0, 32'hDEADBEEF);
        chk("lw_busW_lit", busW, 32'hDEADBEEF);
        chk("lw_addr_lit", last_addr, 32'h104);
        chk("lw_be_lit", {28'd0, last_be}, 32'hF);
        chk("lw_regwr_cnt", n_regwr - r0, 1);

        run_txn(enc_ld(3'b000, 12'd3), 32'h100, 0, 0, 0, 32'h80123456);
        chk("lb_lit", busW, 32'hFFFFFF80);
        run_txn(enc_ld(3'b100, 12'd3), 32'h100, 0, 1, 2, 32'h80123456);
        chk("lbu_lit", busW, 32'h00000080);

        r0 = n_regwr; d0 = n_done;
        run_txn(enc_st(3'b001, 12'd2), 32'h100, 32'h1234ABCD, 0, 0, 0);
        chk("sh_be_lit", {28'd0, last_be}, 32'hC);
        chk("sh_wdata_lit", last_wdata, 32'hABCDABCD);
        chk("sh_we_lit", {31'd0, last_we}, 32'd1);
        chk("sh_done_cnt", n_done - d0, 1);
        chk("sh_no_regwr", n_regwr - r0, 0);

        q0 = n_req;
        run_txn(enc_ld(3'b010, 12'd0), 32'h101, 0, 0, 0, 0);
        run_txn(enc_ld(3'b011, 12'd0), 32'h100, 0, 0, 0, 0);
        chk("illegal_no_req", n_req - q0, 0);

        r0 = n_regwr; q0 = n_req;
        run_txn(enc_ld(3'b010, 12'd8), 32'h400, 0, 3, 5, 32'h0BADF00D);
        chk("delay_regwr_cnt", n_regwr - r0, 1);
        chk("delay_req_cycles", n_req - q0, 4);
        chk("delay_busW_lit", busW, 32'h0BADF00D);

        for (int i = 0; i < 300; i++) rand_txn();

        t4_timeout();

        chk_en = 0;
        @(posedge Clk); #1;
        start = 1; inst = enc_ld(3'b010, 12'd0); rs1 = 32'h300;
        @(posedge Clk); #1;
        start = 0; mem_gnt = 1;
        @(posedge Clk); #1;
        mem_gnt = 0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 Rst_n = 0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_busW", busW, 32'd0);
        chk("arst_bus", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
        chk("arst_flags", {28'd0, done, RegWr, misaligned, bus_err}, 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        @(posedge Clk); #1;
        mem_rvalid = 0;
        r0 = n_regwr;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("late_rv_busy", {31'd0, busy}, 32'd0);
            chk("late_rv_busW", busW, 32'd0);
        end
        chk("late_rv_regwr", n_regwr - r0, 0);
        m_busw = 0;
        set_idle_exp();
        chk_en = 1;
        run_txn(enc_ld(3'b101, 12'd2), 32'h500, 0, 0, 0, 32'h9876F00D);
        chk("post_rst_lhu", busW, 32'h00009876);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
